// File: rtl/uart_tx_serializer.sv
// UART transmit engine: start bit, DATA_WIDTH data bits LSB first, optional parity, stop.
// Optional second stop bit is compiled in with `define UART_TX_TWO_STOP_EN (adds input STOP2).
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [5:0]            Prescale,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`ifdef UART_TX_TWO_STOP_EN
    input  logic                  STOP2,
`endif
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int BIT_W = (DATA_WIDTH > 8) ? 4 : 3;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [5:0]            pre_q, pre_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_second_q, stop_second_d;
    logic                  tx_d, busy_d;
    logic                  last_edge, accept, stop2_in;
    logic [5:0]            pre_in;

`ifdef UART_TX_TWO_STOP_EN
    assign stop2_in = STOP2;
`else
    assign stop2_in = 1'b0;
`endif

    // Prescale values below 4 are treated as 4.
    assign pre_in    = (Prescale < 6'd4) ? 6'd4 : Prescale;
    assign last_edge = (edge_cnt_q == (pre_q - 6'd1));

    // Handshake: a word is taken when Data_Valid=1 in IDLE, or on the final STOP
    // edge (back-to-back); busy is high from the accept edge to the end of the frame.
    // Data_Valid at any other time is ignored and the word is lost.
    always_comb begin
        state_d       = state_q;
        edge_cnt_d    = edge_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        data_d        = data_q;
        pre_d         = pre_q;
        par_en_d      = par_en_q;
        par_bit_d     = par_bit_q;
        stop2_d       = stop2_q;
        stop_second_d = stop_second_q;
        accept        = 1'b0;

        case (state_q)
            IDLE: begin
                if (Data_Valid) accept = 1'b1;
            end
            START: begin
                if (last_edge) begin
                    state_d    = DATA;
                    edge_cnt_d = 6'd0;
                    bit_cnt_d  = '0;
                end else begin
                    edge_cnt_d = edge_cnt_q + 6'd1;
                end
            end
            DATA: begin
                if (last_edge) begin
                    edge_cnt_d = 6'd0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = par_en_q ? PARITY : STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    edge_cnt_d = edge_cnt_q + 6'd1;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    state_d    = STOP;
                    edge_cnt_d = 6'd0;
                end else begin
                    edge_cnt_d = edge_cnt_q + 6'd1;
                end
            end
            STOP: begin
                if (last_edge) begin
                    edge_cnt_d = 6'd0;
                    if (stop2_q && !stop_second_q) begin
                        stop_second_d = 1'b1;
                    end else begin
                        stop_second_d = 1'b0;
                        if (Data_Valid) accept = 1'b1;
                        else            state_d = IDLE;
                    end
                end else begin
                    edge_cnt_d = edge_cnt_q + 6'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = 6'd0;
                bit_cnt_d  = '0;
            end
        endcase

        if (accept) begin
            state_d       = START;
            edge_cnt_d    = 6'd0;
            bit_cnt_d     = '0;
            data_d        = P_DATA;
            pre_d         = pre_in;
            par_en_d      = PAR_EN;
            par_bit_d     = (^P_DATA) ^ PAR_TYP;
            stop2_d       = stop2_in;
            stop_second_d = 1'b0;
        end

        // The line is driven from the next state so TX_OUT changes on the same edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_cnt_d];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            edge_cnt_q    <= 6'd0;
            bit_cnt_q     <= '0;
            data_q        <= '0;
            pre_q         <= 6'd0;
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            stop2_q       <= 1'b0;
            stop_second_q <= 1'b0;
            TX_OUT        <= 1'b1;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            data_q        <= data_d;
            pre_q         <= pre_d;
            par_en_q      <= par_en_d;
            par_bit_q     <= par_bit_d;
            stop2_q       <= stop2_d;
            stop_second_q <= stop_second_d;
            TX_OUT        <= tx_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: per-cycle {busy, TX_OUT} scoreboard fed by a frame model,
// a vector table of single frames, and hand-written back-to-back / mid-frame / reset sequences.
module tb_uart_tx_serializer;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [5:0]    prescale;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
`ifdef UART_TX_TWO_STOP_EN
    logic          stop2;
`endif
    logic          tx_out;
    logic          busy;

    int n_cmp;
    int n_err;
    int busy_run;
    int last_len;
    logic mon_en;
    logic [1:0] mon_exp;
    logic [1:0] exp_q[$];

    typedef struct {
        logic [5:0]    p;
        logic [DW-1:0] data;
        logic          pe;
        logic          pt;
        logic          par;
        int            len;
    } vec_t;

    vec_t vecs[6];

    uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .CLK        (clk),
        .RST        (rst),
        .Prescale   (prescale),
        .P_DATA     (p_data),
        .Data_Valid (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
`ifdef UART_TX_TWO_STOP_EN
        .STOP2      (stop2),
`endif
        .TX_OUT     (tx_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one comparison per cycle, 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            busy_run = 0;
        end else if (mon_en) begin
            if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
            else                  mon_exp = 2'b01;
            n_cmp++;
            if ({busy, tx_out} !== mon_exp) begin
                n_err++;
                $display("FAIL line t=%0t busy/tx got %b required %b", $time, {busy, tx_out}, mon_exp);
            end
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_len = busy_run;
                busy_run = 0;
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Frame model: expected {busy, tx} per cycle.
    task automatic push_frame(input logic [5:0] p, input logic [DW-1:0] d,
                              input logic pe, input logic par, input logic s2);
        int peff;
        peff = (p < 6'd4) ? 4 : int'(p);
        for (int i = 0; i < peff; i++) exp_q.push_back(2'b10);
        for (int b = 0; b < DW; b++)
            for (int i = 0; i < peff; i++) exp_q.push_back({1'b1, d[b]});
        if (pe)
            for (int i = 0; i < peff; i++) exp_q.push_back({1'b1, par});
        for (int i = 0; i < peff * (s2 ? 2 : 1); i++) exp_q.push_back(2'b11);
    endtask

    task automatic start_frame(input logic [5:0] p, input logic [DW-1:0] d, input logic pe,
                               input logic pt, input logic par, input logic s2);
        @(negedge clk);
        prescale   = p;
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
`ifdef UART_TX_TWO_STOP_EN
        stop2      = s2;
`endif
        data_valid = 1'b1;
        push_frame(p, d, pe, par, s2);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s drain: got %0d pending required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; busy_run = 0; last_len = 0; mon_en = 1'b0; mon_exp = 2'b01;
        rst = 1'b0; prescale = 6'd8; p_data = '0; data_valid = 1'b0;
        par_en = 1'b0; par_typ = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop2 = 1'b0;
`endif
        vecs[0] = '{p: 6'd8,  data: 8'hA5, pe: 1'b1, pt: 1'b0, par: 1'b0, len: 88};
        vecs[1] = '{p: 6'd16, data: 8'h01, pe: 1'b1, pt: 1'b1, par: 1'b0, len: 176};
        vecs[2] = '{p: 6'd16, data: 8'h01, pe: 1'b0, pt: 1'b0, par: 1'b0, len: 160};
        vecs[3] = '{p: 6'd2,  data: 8'h3C, pe: 1'b1, pt: 1'b1, par: 1'b1, len: 44};
        vecs[4] = '{p: 6'd63, data: 8'hFF, pe: 1'b1, pt: 1'b0, par: 1'b0, len: 693};
        vecs[5] = '{p: 6'd5,  data: 8'h80, pe: 1'b0, pt: 1'b1, par: 1'b0, len: 50};

        // Reset values, then 20 idle cycles checked by the monitor.
        #12;
        check("reset_tx", int'(tx_out), 1);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            start_frame(vecs[v].p, vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].par, 1'b0);
            wait_drain("vec");
            check($sformatf("vec%0d_busy_len", v), last_len, vecs[v].len);
        end

        // Back-to-back: Data_Valid held high, word changed to 0xAA after the first accept.
        @(negedge clk);
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; p_data = 8'h55; data_valid = 1'b1;
        push_frame(6'd8, 8'h55, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        p_data = 8'hAA;
        push_frame(6'd8, 8'hAA, 1'b0, 1'b0, 1'b0);
        repeat (80) @(negedge clk);
        data_valid = 1'b0;
        wait_drain("b2b");
        check("b2b_busy_len", last_len, 160);

        // Mid-frame input changes and a stray Data_Valid pulse do not disturb the frame.
        start_frame(6'd8, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        prescale = 6'd32; p_data = 8'hFF; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        wait_drain("midchg");
        check("midchg_busy_len", last_len, 88);

        // Asynchronous reset during data bit 3 (a 0 bit), then a clean frame.
        start_frame(6'd8, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (34) @(negedge clk);
        #2;
        mon_en = 1'b0;
        exp_q.delete();
        rst = 1'b0;
        #1;
        check("async_rst_tx", int'(tx_out), 1);
        check("async_rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        start_frame(6'd8, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain("post_rst");
        check("post_rst_busy_len", last_len, 88);

`ifdef UART_TX_TWO_STOP_EN
        start_frame(6'd8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain("stop2");
        check("stop2_busy_len", last_len, 96);
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit engine. The UART RX path oversamples by Prescale, and this block drives its serial line at the same baud.
- Runs on the same oversampled CLK as the receiver; each bit lasts Prescale CLK cycles.
- Accepts a parallel word through a valid/busy handshake.
- Emits start bit, data bits LSB first, optional parity, then stop.
- Sits between the system-side register file/FIFO and the TX pad.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal range 5..9)

Ports:
CLK  input  1  system/oversample clock, rising edge
RST  input  1  asynchronous active-low reset
Prescale  input  6  CLK cycles per bit; legal values 4..63; values 0..3 behave as 4
P_DATA  input  DATA_WIDTH  parallel word to transmit
Data_Valid  input  1  P_DATA valid; accepted only when ready (see Behaviour)
PAR_EN  input  1  1 = parity bit inserted
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line, idle high, registered
busy  output  1  high from the accept edge through the end of the frame, registered

Behaviour:
- Reset values:
  - TX_OUT=1, busy=0, state=IDLE.
  - Edge counter, bit counter, shift register and latched config all 0.
  - Reset is asynchronous and takes effect mid-frame: the line returns high at once and the frame is dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Internal counters:
  - edge_cnt runs 0..P-1, where P is the Prescale latched at accept after clamping.
  - bit_cnt runs 0..DATA_WIDTH-1.
- Accept:
  - Occurs in IDLE with Data_Valid=1 at edge N.
  - At edge N: P_DATA, Prescale, PAR_EN and PAR_TYP are latched; parity is computed from the latched data; state goes to START, edge_cnt=0.
  - TX_OUT=0 and busy=1 are visible after edge N. Latency is one cycle.
  - Input changes after accept do not affect the current frame.
- Data_Valid while busy=1 and not at the back-to-back point is ignored and the word is lost. The producer must wait for busy=0.
- State transitions, each taken on the edge where edge_cnt==P-1, with edge_cnt cleared to 0:
  - START to DATA.
  - DATA: shift to the next bit. After bit DATA_WIDTH-1, go to PARITY if PAR_EN else STOP.
  - PARITY to STOP.
  - STOP to IDLE with busy=0, unless back-to-back applies.
- Line values: TX_OUT follows the current state's bit.
  - START: 0.
  - DATA: latched_data[bit_cnt].
  - PARITY: parity bit.
  - STOP: 1.
  - IDLE: 1.
- Parity bit: PAR_TYP=0 gives XOR of the data bits; PAR_TYP=1 gives the inverted XOR.
- Back-to-back: if Data_Valid=1 on the final STOP edge (edge_cnt==P-1), the word is accepted on that edge.
  - FSM goes directly to START and busy stays 1.
  - No idle gap; the stop bit keeps its full length.
- Frame length: P*(2+DATA_WIDTH+PAR_EN) cycles, plus one stop period more when the optional feature is enabled and STOP2=1.
- Every TX_OUT transition is aligned to an edge_cnt rollover; there are no glitches because the output is registered.

Optional Feature:
Macro UART_TX_TWO_STOP_EN.
- Defined:
  - Adds input port STOP2 (1 bit), latched at accept.
  - STOP2=1 makes the STOP state last 2*P cycles; the back-to-back point moves to the end of the second period.
  - STOP2=0 behaves as without the macro.
- Undefined: port STOP2 is absent and STOP always lasts exactly P cycles.

Test Plan:
1. Reset, then idle 20 cycles -> TX_OUT=1 and busy=0 throughout.
2. Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, Data_Valid pulse -> line sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 8 cycles. busy is high for exactly 88 cycles, starting the cycle after the pulse.
3. Prescale=16, PAR_EN=1, PAR_TYP=1, P_DATA=0x01 -> parity bit=0, frame 176 cycles. Repeat with PAR_EN=0 -> 10 bits, 160 cycles, no parity slot.
4. Prescale=8, PAR_EN=0, Data_Valid held high with 0x55 then 0xAA presented at the final STOP edge -> two contiguous frames with no idle cycle between them. busy stays 1 for 160 cycles. A Data_Valid pulse mid-frame 1 is ignored.
5. Change Prescale from 8 to 32 and P_DATA mid-frame -> the current frame keeps 8-cycle bits and its original data.
6. Assert RST low mid-DATA bit 3 -> TX_OUT=1 and busy=0 with no clock edge needed. After release, a new frame for 0x3C transmits correctly. With UART_TX_TWO_STOP_EN and STOP2=1 at Prescale=8: stop high for 16 cycles, busy total 96 cycles with parity.
